// File: rtl/l2_cpu_req_issuer_pkg.sv
// Shared types and encodings for the CPU-side L2 request issuer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package l2_cpu_req_issuer_pkg;

    // Line geometry; both values must be powers of two.
    localparam int WORDS_PER_LINE = 4;
    localparam int BYTES_PER_WORD = 8;

    localparam int WORD_BITS     = BYTES_PER_WORD * 8;
    localparam int LINE_BITS     = WORDS_PER_LINE * WORD_BITS;
    localparam int ADDR_BITS     = 32;
    localparam int BYTE_OFF_BITS = $clog2(BYTES_PER_WORD);
    localparam int WORD_IDX_BITS = $clog2(WORDS_PER_LINE);
    localparam int HSIZE_BITS    = 3;
    localparam int CPU_MSG_BITS  = 2;
    localparam int BRESP_BITS    = 2;
    localparam int AMO_BITS      = 6;
    localparam int DCS_BITS      = 2;
    localparam int CID_BITS      = 4;
    localparam int STRAY_BITS    = 8;

    typedef logic [ADDR_BITS-1:0]                     addr_t;
    typedef logic [WORD_BITS-1:0]                     word_t;
    typedef logic [WORDS_PER_LINE-1:0][WORD_BITS-1:0] line_t;
    typedef logic [WORD_IDX_BITS-1:0]                 word_idx_t;
    typedef logic [HSIZE_BITS-1:0]                    hsize_t;
    typedef logic [CPU_MSG_BITS-1:0]                  cpu_msg_t;
    typedef logic [BRESP_BITS-1:0]                    bresp_t;

    // L2 request message encodings (spandex CPU-side messages).
    localparam cpu_msg_t CPU_READ  = 2'b00;
    localparam cpu_msg_t CPU_WRITE = 2'b01;

    // Write response encodings (AXI-style).
    localparam bresp_t BRESP_OKAY   = 2'b00;
    localparam bresp_t BRESP_EXOKAY = 2'b01;
    localparam bresp_t BRESP_SLVERR = 2'b10;
    localparam bresp_t BRESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        REQ        = 3'd1,
        WAIT_RD    = 3'd2,
        WAIT_WR    = 3'd3,
        RSP        = 3'd4,
        FLUSH_REQ  = 3'd5,
        FLUSH_WAIT = 3'd6,
        FENCE_REQ  = 3'd7
    } l2_issuer_state_t;

    // Word slot inside a line addressed by a byte address.
    function automatic word_idx_t word_index(input addr_t addr);
        return addr[BYTE_OFF_BITS +: WORD_IDX_BITS];
    endfunction

endpackage

// File: rtl/l2_cpu_req_issuer_line_word_select.sv
// Picks one word out of a cache line by word index.
// Latency: combinational, zero cycles.
// Backpressure: none; pure datapath.
module line_word_select
    import l2_cpu_req_issuer_pkg::*;
(
    input  line_t     line,
    input  word_idx_t idx,
    output word_t     word
);

    // The line is a packed array of words, so the index selects a whole word lane.
    assign word = line[idx];

endmodule

// File: rtl/l2_cpu_req_issuer.sv
// Core load/store/flush/fence port to single-outstanding L2 cpu_req transactions.
// Latency: request valid to L2 one cycle after core accept; core response one cycle after rd_rsp/bresp.
// Backpressure: core readies only in IDLE; every L2-facing valid holds its fields until ready.
module l2_cpu_req_issuer
    import l2_cpu_req_issuer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    core_req_valid,
    output logic                    core_req_ready,
    input  logic                    core_req_we,
    input  logic [ADDR_BITS-1:0]    core_req_addr,
    input  logic [WORD_BITS-1:0]    core_req_wdata,
    input  logic [HSIZE_BITS-1:0]   core_req_hsize,
    input  logic [1:0]              core_req_hprot,

    output logic                    core_rsp_valid,
    input  logic                    core_rsp_ready,
    output logic [WORD_BITS-1:0]    core_rsp_rdata,
    output logic                    core_rsp_err,

    input  logic                    core_flush_valid,
    output logic                    core_flush_ready,
    input  logic                    core_flush_data,

    input  logic                    core_fence_valid,
    output logic                    core_fence_ready,
    input  logic [1:0]              core_fence_data,

    output logic                    l2_cpu_req_valid,
    input  logic                    l2_cpu_req_ready,
    output logic [CPU_MSG_BITS-1:0] l2_cpu_req_data_cpu_msg,
    output logic [HSIZE_BITS-1:0]   l2_cpu_req_data_hsize,
    output logic [1:0]              l2_cpu_req_data_hprot,
    output logic [ADDR_BITS-1:0]    l2_cpu_req_data_addr,
    output logic [WORD_BITS-1:0]    l2_cpu_req_data_word,
    output logic [AMO_BITS-1:0]     l2_cpu_req_data_amo,
    output logic                    l2_cpu_req_data_aq,
    output logic                    l2_cpu_req_data_rl,
    output logic                    l2_cpu_req_data_dcs_en,
    output logic                    l2_cpu_req_data_use_owner_pred,
    output logic [DCS_BITS-1:0]     l2_cpu_req_data_dcs,
    output logic [CID_BITS-1:0]     l2_cpu_req_data_pred_cid,

    input  logic                    l2_rd_rsp_valid,
    output logic                    l2_rd_rsp_ready,
    input  logic [LINE_BITS-1:0]    l2_rd_rsp_data_line,

    input  logic                    l2_bresp_valid,
    output logic                    l2_bresp_ready,
    input  logic [BRESP_BITS-1:0]   l2_bresp_data,

    output logic                    l2_flush_valid,
    input  logic                    l2_flush_ready,
    output logic                    l2_flush_data,

    output logic                    l2_fence_valid,
    input  logic                    l2_fence_ready,
    output logic [1:0]              l2_fence_data,

    input  logic                    flush_done,
    output logic [STRAY_BITS-1:0]   stray_cnt
);

    l2_issuer_state_t state_q;
    l2_issuer_state_t state_d;

    // Registered copy of the accepted operation; the core may change its inputs freely afterwards.
    logic             req_we_q;
    addr_t            req_addr_q;
    word_t            req_wdata_q;
    hsize_t           req_hsize_q;
    logic             req_hprot0_q;
    logic             flush_data_q;
    logic [1:0]       fence_data_q;

    // Response held for the core.
    word_t            rdata_q;
    logic             err_q;

    logic [STRAY_BITS-1:0] stray_q;
    logic [STRAY_BITS:0]   stray_sum;

    logic             grant_flush;
    logic             grant_fence;
    logic             grant_req;
    logic             rd_beat;
    logic             bresp_beat;
    logic             rd_stray;
    logic             wr_stray;
    word_t            sel_word;
    word_idx_t        word_idx;

    // Only hprot bit 0 carries meaning downstream; bit 1 is deliberately dropped.
    logic             unused_hprot;
    assign unused_hprot = core_req_hprot[1];

    // Priority flush > fence > req falls out of the ready decode below.
    assign grant_flush = core_flush_valid & core_flush_ready;
    assign grant_fence = core_fence_valid & core_fence_ready;
    assign grant_req   = core_req_valid   & core_req_ready;

    assign rd_beat     = l2_rd_rsp_valid & l2_rd_rsp_ready;
    assign bresp_beat  = l2_bresp_valid  & l2_bresp_ready;
    // Beats that arrive outside their wait state are accepted and thrown away.
    assign rd_stray    = rd_beat    & (state_q != WAIT_RD);
    assign wr_stray    = bresp_beat & (state_q != WAIT_WR);

    assign stray_sum   = {1'b0, stray_q} + {{STRAY_BITS{1'b0}}, rd_stray}
                                         + {{STRAY_BITS{1'b0}}, wr_stray};

    assign word_idx    = word_index(req_addr_q);

    line_word_select u_line_word_select (
        .line (l2_rd_rsp_data_line),
        .idx  (word_idx),
        .word (sel_word)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: one operation at a time, each waits for its own completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (core_flush_valid) begin
                    state_d = FLUSH_REQ;
                end else if (core_fence_valid) begin
                    state_d = FENCE_REQ;
                end else if (core_req_valid) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (l2_cpu_req_ready) begin
                    state_d = req_we_q ? WAIT_WR : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (l2_rd_rsp_valid) begin
                    state_d = RSP;
                end
            end
            WAIT_WR: begin
                if (l2_bresp_valid) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (core_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            FLUSH_REQ: begin
                // A completion pulse coincident with the handshake must not be lost.
                if (l2_flush_ready) begin
                    state_d = flush_done ? IDLE : FLUSH_WAIT;
                end
            end
            FLUSH_WAIT: begin
                if (flush_done) begin
                    state_d = IDLE;
                end
            end
            FENCE_REQ: begin
                if (l2_fence_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        core_req_ready   = 1'b0;
        core_flush_ready = 1'b0;
        core_fence_ready = 1'b0;
        core_rsp_valid   = 1'b0;
        l2_cpu_req_valid = 1'b0;
        l2_flush_valid   = 1'b0;
        l2_fence_valid   = 1'b0;
        l2_rd_rsp_ready  = (state_q != WAIT_WR);
        l2_bresp_ready   = (state_q != WAIT_RD);
        case (state_q)
            IDLE: begin
                core_flush_ready = 1'b1;
                core_fence_ready = ~core_flush_valid;
                core_req_ready   = ~core_flush_valid & ~core_fence_valid;
            end
            REQ:       l2_cpu_req_valid = 1'b1;
            RSP:       core_rsp_valid   = 1'b1;
            FLUSH_REQ: l2_flush_valid   = 1'b1;
            FENCE_REQ: l2_fence_valid   = 1'b1;
            default: begin
            end
        endcase
    end

    // Operation capture, response capture and stray beat accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_hsize_q  <= '0;
            req_hprot0_q <= 1'b0;
            flush_data_q <= 1'b0;
            fence_data_q <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            stray_q      <= '0;
        end else begin
            if (grant_flush) begin
                flush_data_q <= core_flush_data;
            end
            if (grant_fence) begin
                fence_data_q <= core_fence_data;
            end
            if (grant_req) begin
                req_we_q     <= core_req_we;
                req_addr_q   <= core_req_addr;
                req_wdata_q  <= core_req_wdata;
                req_hsize_q  <= core_req_hsize;
                req_hprot0_q <= core_req_hprot[0];
            end
            if (rd_beat && state_q == WAIT_RD) begin
                rdata_q <= sel_word;
                err_q   <= 1'b0;
            end
            if (bresp_beat && state_q == WAIT_WR) begin
                rdata_q <= '0;
                err_q   <= (l2_bresp_data != BRESP_OKAY);
            end
            stray_q <= stray_sum[STRAY_BITS] ? {STRAY_BITS{1'b1}} : stray_sum[STRAY_BITS-1:0];
        end
    end

    assign core_rsp_rdata                 = rdata_q;
    assign core_rsp_err                   = err_q;

    assign l2_cpu_req_data_cpu_msg        = req_we_q ? CPU_WRITE : CPU_READ;
    assign l2_cpu_req_data_hsize          = req_hsize_q;
    assign l2_cpu_req_data_hprot          = {1'b0, req_hprot0_q};
    assign l2_cpu_req_data_addr           = req_addr_q;
    assign l2_cpu_req_data_word           = req_wdata_q;
    // Plain loads and stores only: no atomics, ordering bits or coherence hints.
    assign l2_cpu_req_data_amo            = '0;
    assign l2_cpu_req_data_aq             = 1'b0;
    assign l2_cpu_req_data_rl             = 1'b0;
    assign l2_cpu_req_data_dcs_en         = 1'b0;
    assign l2_cpu_req_data_use_owner_pred = 1'b0;
    assign l2_cpu_req_data_dcs            = '0;
    assign l2_cpu_req_data_pred_cid       = '0;

    assign l2_flush_data                  = flush_data_q;
    assign l2_fence_data                  = fence_data_q;
    assign stray_cnt                      = stray_q;

endmodule
